// File: rtl/multiplier_pkg.sv
// Shared constants, Booth digit encoding and carry-save helpers for the
// 32x32 radix-4 Booth / carry-save-tree multiplier.
package multiplier_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int NUM_PP = 17;
    localparam int ROW_W  = OP_W + 2;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}; the all-ones window is a zero digit, so neg stays low.
    function automatic booth_digit_t booth_decode(input logic [2:0] win);
        booth_digit_t d;
        d.one = win[1] ^ win[0];
        d.two = (win[2] & ~win[1] & ~win[0]) | (~win[2] & win[1] & win[0]);
        d.neg = win[2] & ~(win[1] & win[0]);
        return d;
    endfunction

    // Each row carries an inverted sign bit at weight 2^(33+2i); this folds the
    // matching -2^(33+2i) terms of all rows into one constant (mod 2^64).
    function automatic logic [PROD_W-1:0] sign_ext_const();
        logic [PROD_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            acc = acc + (64'd1 << (OP_W + 1 + 2 * i));
        end
        return ~acc + 64'd1;
    endfunction

    localparam logic [PROD_W-1:0] SIGN_EXT_K = sign_ext_const();

    function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y,
                                                    input logic [PROD_W-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Row count after one 3:2 level: every full group of three becomes two rows.
    function automatic int csa_rows(input int n);
        return (n / 3) * 2 + (n % 3);
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial-product row: selects 0/+-A/+-2A from a 3-bit
// multiplier window and places it at weight 4^ROW_IDX with its inverted sign bit.
module booth_pp_gen
    import multiplier_pkg::*;
#(
    parameter int ROW_IDX = 0
) (
    input  logic [OP_W-1:0]   a,
    input  logic [2:0]        win,
    output logic [PROD_W-1:0] row,
    output logic              neg
);

    booth_digit_t digit;
    logic [OP_W:0] mag;
    logic [OP_W:0] sel;

    assign digit = booth_decode(win);

    assign mag = ({(OP_W + 1){digit.one}} & {1'b0, a})
               | ({(OP_W + 1){digit.two}} & {a, 1'b0});

    // One's complement here; the +1 is injected separately at the row LSB.
    assign sel = mag ^ {(OP_W + 1){digit.neg}};

    assign row = {{(PROD_W - ROW_W){1'b0}}, ~digit.neg, sel} << (2 * ROW_IDX);
    assign neg = digit.neg;

endmodule

// File: rtl/multiplier_32bits_v10.sv
// Unsigned 32x32->64 multiplier: Booth rows, 3:2 carry-save tree and a
// registered sum/carry pair in stage 1, carry-propagate add in stage 2.
module multiplier_32bits_v10
    import multiplier_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic [PROD_W-1:0] product
);

    localparam int L0_N = NUM_PP + 1;
    localparam int L1_N = csa_rows(L0_N);
    localparam int L2_N = csa_rows(L1_N);
    localparam int L3_N = csa_rows(L2_N);
    localparam int L4_N = csa_rows(L3_N);
    localparam int L5_N = csa_rows(L4_N);

    logic [2*NUM_PP:0]   b_ext;
    logic [NUM_PP-1:0]   pp_neg;
    logic [PROD_W-1:0]   neg_spread;
    logic [PROD_W-1:0]   lvl0 [L0_N];
    logic [PROD_W-1:0]   lvl1 [L1_N];
    logic [PROD_W-1:0]   lvl2 [L2_N];
    logic [PROD_W-1:0]   lvl3 [L3_N];
    logic [PROD_W-1:0]   lvl4 [L4_N];
    logic [PROD_W-1:0]   lvl5 [L5_N];
    logic [PROD_W-1:0]   sum_next;
    logic [PROD_W-1:0]   carry_next;
    logic [PROD_W-1:0]   sum_reg;
    logic [PROD_W-1:0]   carry_reg;
    logic [PROD_W-1:0]   product_next;

    // Zero-extend B to 34 bits and append the implicit b[-1] = 0.
    assign b_ext = {2'b00, B, 1'b0};

    genvar gi;

    for (gi = 0; gi < NUM_PP; gi++) begin : g_pp
        booth_pp_gen #(
            .ROW_IDX (gi)
        ) u_pp (
            .a   (A),
            .win (b_ext[2*gi+2 -: 3]),
            .row (lvl0[gi]),
            .neg (pp_neg[gi])
        );
    end

    always_comb begin
        neg_spread = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            neg_spread[2*i] = pp_neg[i];
        end
    end

    // The constant has no bits below 33, so the +1 injections never collide with it.
    assign lvl0[NUM_PP] = SIGN_EXT_K | neg_spread;

    for (gi = 0; gi < L0_N / 3; gi++) begin : g_l1_csa
        assign lvl1[2*gi]   = csa_sum  (lvl0[3*gi], lvl0[3*gi+1], lvl0[3*gi+2]);
        assign lvl1[2*gi+1] = csa_carry(lvl0[3*gi], lvl0[3*gi+1], lvl0[3*gi+2]);
    end
    for (gi = 0; gi < L0_N % 3; gi++) begin : g_l1_pass
        assign lvl1[2*(L0_N/3)+gi] = lvl0[3*(L0_N/3)+gi];
    end

    for (gi = 0; gi < L1_N / 3; gi++) begin : g_l2_csa
        assign lvl2[2*gi]   = csa_sum  (lvl1[3*gi], lvl1[3*gi+1], lvl1[3*gi+2]);
        assign lvl2[2*gi+1] = csa_carry(lvl1[3*gi], lvl1[3*gi+1], lvl1[3*gi+2]);
    end
    for (gi = 0; gi < L1_N % 3; gi++) begin : g_l2_pass
        assign lvl2[2*(L1_N/3)+gi] = lvl1[3*(L1_N/3)+gi];
    end

    for (gi = 0; gi < L2_N / 3; gi++) begin : g_l3_csa
        assign lvl3[2*gi]   = csa_sum  (lvl2[3*gi], lvl2[3*gi+1], lvl2[3*gi+2]);
        assign lvl3[2*gi+1] = csa_carry(lvl2[3*gi], lvl2[3*gi+1], lvl2[3*gi+2]);
    end
    for (gi = 0; gi < L2_N % 3; gi++) begin : g_l3_pass
        assign lvl3[2*(L2_N/3)+gi] = lvl2[3*(L2_N/3)+gi];
    end

    for (gi = 0; gi < L3_N / 3; gi++) begin : g_l4_csa
        assign lvl4[2*gi]   = csa_sum  (lvl3[3*gi], lvl3[3*gi+1], lvl3[3*gi+2]);
        assign lvl4[2*gi+1] = csa_carry(lvl3[3*gi], lvl3[3*gi+1], lvl3[3*gi+2]);
    end
    for (gi = 0; gi < L3_N % 3; gi++) begin : g_l4_pass
        assign lvl4[2*(L3_N/3)+gi] = lvl3[3*(L3_N/3)+gi];
    end

    for (gi = 0; gi < L4_N / 3; gi++) begin : g_l5_csa
        assign lvl5[2*gi]   = csa_sum  (lvl4[3*gi], lvl4[3*gi+1], lvl4[3*gi+2]);
        assign lvl5[2*gi+1] = csa_carry(lvl4[3*gi], lvl4[3*gi+1], lvl4[3*gi+2]);
    end
    for (gi = 0; gi < L4_N % 3; gi++) begin : g_l5_pass
        assign lvl5[2*(L4_N/3)+gi] = lvl4[3*(L4_N/3)+gi];
    end

    // Tree ends at three rows; a last 3:2 level yields the registered pair.
    assign sum_next   = csa_sum  (lvl5[0], lvl5[1], lvl5[2]);
    assign carry_next = csa_carry(lvl5[0], lvl5[1], lvl5[2]);

    assign product_next = sum_reg + carry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            carry_reg <= '0;
            product   <= '0;
        end else begin
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            product   <= product_next;
        end
    end

endmodule

// File: tb/tb_multiplier_32bits_v10.sv
// Directed and reference-checked stimulus for the two-stage 32x32 multiplier.
module tb_multiplier_32bits_v10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [63:0] product;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [63:0] exp_pipe [2];
    string       tag_pipe [2];
    bit          chk_pipe [2];

    logic [31:0] va [4] = '{32'h5829EC10, 32'h3489BE8F, 32'hAB5BAFFF, 32'hFFFFFFFF};
    logic [31:0] vb [4] = '{32'h123BBBCF, 32'hFFFFFFFF, 32'hFFF10010, 32'hFFFFFFFF};
    logic [63:0] vp [4] = '{64'h064784F0710590F0, 64'h3489BE8ECB764171,
                            64'hAB51A5AA65C9FFF0, 64'hFFFFFFFE00000001};

    multiplier_32bits_v10 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: product=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: product=%h", tag, got);
        end
    endtask

    task automatic push(input logic [63:0] exp, input string tag, input bit chk);
        exp_pipe[1] = exp_pipe[0];
        tag_pipe[1] = tag_pipe[0];
        chk_pipe[1] = chk_pipe[0];
        exp_pipe[0] = exp;
        tag_pipe[0] = tag;
        chk_pipe[0] = chk;
    endtask

    task automatic flush_pipe();
        chk_pipe[0] = 1'b0;
        chk_pipe[1] = 1'b0;
    endtask

    // Apply one operand pair per cycle; the result of the pair applied two calls earlier is checked.
    task automatic cycle(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag, input bit chk);
        @(negedge clk);
        if (chk_pipe[1]) check_val(tag_pipe[1], product, exp_pipe[1]);
        push(exp, tag, chk);
        A = a;
        B = b;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        flush_pipe();
        rst_n = 1'b0;
        A = $urandom;
        B = $urandom;
        repeat (3) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            check_val("rst_hold", product, 64'h0);
        end
        @(negedge clk);
        A = '0;
        B = '0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("rst_release_zero", product, 64'h0);
        end

        for (int i = 0; i < 4; i++) begin
            cycle(va[i], vb[i], vp[i], $sformatf("dir%0d", i), 1'b1);
            cycle('0, '0, 64'h0, "dir_gap", 1'b1);
            cycle('0, '0, 64'h0, "dir_gap", 1'b1);
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                cycle(va[i], vb[i], vp[i], $sformatf("b2b%0d", i), 1'b1);
            end
        end

        cycle(32'h00000000, 32'hFFFFFFFF, 64'h0, "a_zero", 1'b1);
        cycle(32'hFFFFFFFF, 32'h00000000, 64'h0, "b_zero", 1'b1);
        cycle(32'h80000000, 32'h80000000, 64'h4000000000000000, "msb_msb", 1'b1);
        cycle(32'h80000000, 32'h00000003, 64'h0000000180000000, "msb_x3", 1'b1);

        // Mid-stream reset: clears immediately and drops everything in flight.
        cycle(va[0], vb[0], vp[0], "pre_rst0", 1'b1);
        cycle(va[1], vb[1], vp[1], "pre_rst1", 1'b1);
        cycle(va[2], vb[2], vp[2], "pre_rst2", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_clear", product, 64'h0);
        flush_pipe();
        repeat (2) begin
            @(negedge clk);
            A = $urandom;
            B = $urandom;
            check_val("mid_rst_hold", product, 64'h0);
        end
        @(negedge clk);
        push(64'h0, "post_rst_first_edge", 1'b1);
        push(vp[3], "post_rst_second_edge", 1'b1);
        A = va[3];
        B = vb[3];
        rst_n = 1'b1;
        cycle('0, '0, 64'h0, "post_rst_tail", 1'b1);
        cycle('0, '0, 64'h0, "post_rst_tail", 1'b1);

        for (int i = 0; i < 32; i++) begin
            ra = 32'h1 << i;
            rb = $urandom | 32'h80000000;
            cycle(ra, rb, {32'h0, ra} * {32'h0, rb}, $sformatf("walk_a%0d", i), 1'b1);
        end
        for (int i = 0; i < 32; i++) begin
            ra = $urandom;
            rb = 32'h1 << i;
            cycle(ra, rb, {32'h0, ra} * {32'h0, rb}, $sformatf("walk_b%0d", i), 1'b1);
        end

        for (int k = 0; k < 10000; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 0) ra = ra | 32'h80000000;
            if (k % 3 == 0) rb = rb | 32'h80000000;
            cycle(ra, rb, {32'h0, ra} * {32'h0, rb}, "rnd", 1'b1);
        end

        cycle('0, '0, 64'h0, "drain", 1'b0);
        cycle('0, '0, 64'h0, "drain", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
